// File: rtl/fft8_seq_pkg.sv
// Shared definitions for the 8-point frame sequencer: state encoding, sizes,
// and the W8 twiddle table expressed as integer/root-half coefficient pairs.
package fft8_seq_pkg;

   localparam int N_PTS  = 8;
   localparam int IDX_W  = 3;
   // root(1/2) is applied as (v*181 + 128) >>> 8, i.e. rounded to nearest
   localparam int TW_K   = 181;
   localparam int TW_RND = 128;
   localparam int TW_SH  = 8;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } state_e;

   // W8^m = (re_a + re_b*c) + j(im_a + im_b*c), c = root(1/2), coefficients in {-1,0,1}
   typedef struct packed {
      logic signed [1:0] re_a;
      logic signed [1:0] re_b;
      logic signed [1:0] im_a;
      logic signed [1:0] im_b;
   } tw_t;

   function automatic tw_t twiddle(input logic [IDX_W-1:0] m);
      tw_t t;
      t = '0;
      case (m)
         3'd0: t.re_a = 2'sd1;
         3'd1: begin t.re_b = 2'sd1;  t.im_b = -2'sd1; end
         3'd2: t.im_a = -2'sd1;
         3'd3: begin t.re_b = -2'sd1; t.im_b = -2'sd1; end
         3'd4: t.re_a = -2'sd1;
         3'd5: begin t.re_b = -2'sd1; t.im_b = 2'sd1;  end
         3'd6: t.im_a = 2'sd1;
         3'd7: begin t.re_b = 2'sd1;  t.im_b = 2'sd1;  end
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fft8.sv
// Combinational 8-point DFT of unsigned real samples; results wrap modulo 2^DW.
// Root-half terms are summed per bin component first, then scaled once with rounding.
module fft8
   import fft8_seq_pkg::*;
#(
   parameter int DW = 4
) (
   input  logic [N_PTS-1:0][DW-1:0] x,
   output logic [N_PTS-1:0][DW-1:0] y_re,
   output logic [N_PTS-1:0][DW-1:0] y_im
);

   localparam int AW = DW + 16;

   function automatic logic signed [AW-1:0] tmul(input logic signed [AW-1:0] v,
                                                 input logic signed [1:0]    c);
      if (c == 2'sd1)
         return v;
      else if (c == -2'sd1)
         return -v;
      else
         return '0;
   endfunction

   function automatic logic signed [AW-1:0] scale_c(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] p;
      p = v * $signed(AW'(TW_K)) + $signed(AW'(TW_RND));
      return p >>> TW_SH;
   endfunction

   logic signed [AW-1:0] re_a, re_b, im_a, im_b, xv, sum_re, sum_im;
   tw_t                  tw;

   always_comb begin
      y_re   = '0;
      y_im   = '0;
      re_a   = '0;
      re_b   = '0;
      im_a   = '0;
      im_b   = '0;
      xv     = '0;
      sum_re = '0;
      sum_im = '0;
      tw     = '0;
      for (int k = 0; k < N_PTS; k++) begin
         re_a = '0;
         re_b = '0;
         im_a = '0;
         im_b = '0;
         for (int n = 0; n < N_PTS; n++) begin
            tw   = twiddle(IDX_W'(n * k));
            xv   = $signed({{(AW-DW){1'b0}}, x[n]});
            re_a = re_a + tmul(xv, tw.re_a);
            re_b = re_b + tmul(xv, tw.re_b);
            im_a = im_a + tmul(xv, tw.im_a);
            im_b = im_b + tmul(xv, tw.im_b);
         end
         sum_re  = re_a + scale_c(re_b);
         sum_im  = im_a + scale_c(im_b);
         y_re[k] = sum_re[DW-1:0];
         y_im[k] = sum_im[DW-1:0];
      end
   end

endmodule

// File: rtl/fft8_frame_seq.sv
// Collects 8 samples, waits SETTLE cycles for the fft8 core, then streams 8 bins.
// Bin 0 appears 8+SETTLE cycles after the first sample; bins hold while out_ready is low.
module fft8_frame_seq
   import fft8_seq_pkg::*;
#(
   parameter int DW     = 4,
   parameter int SETTLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_re,
   output logic [DW-1:0]    out_im,
   output logic [IDX_W-1:0] out_idx,
   output logic             busy,
   output logic             frame_done
);

   localparam int SW = 4;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          cnt_q, cnt_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [SW-1:0]             settle_q, settle_d;
   logic [N_PTS-1:0][DW-1:0]  samp_q, samp_d;
   logic [N_PTS-1:0][DW-1:0]  res_re_q, res_re_d;
   logic [N_PTS-1:0][DW-1:0]  res_im_q, res_im_d;
   logic [N_PTS-1:0][DW-1:0]  fft_re, fft_im;

   fft8 #(.DW(DW)) u_fft8 (
      .x    (samp_q),
      .y_re (fft_re),
      .y_im (fft_im)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= LOAD;
         cnt_q    <= '0;
         idx_q    <= '0;
         settle_q <= '0;
         samp_q   <= '0;
         res_re_q <= '0;
         res_im_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         samp_q   <= samp_d;
         res_re_q <= res_re_d;
         res_im_q <= res_im_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      settle_d   = settle_q;
      samp_d     = samp_q;
      res_re_d   = res_re_q;
      res_im_d   = res_im_q;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      frame_done = 1'b0;
      case (state_q)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               samp_d[cnt_q] = in_data;
               cnt_d         = cnt_q + 1'b1;
               if (cnt_q == IDX_W'(N_PTS - 1)) begin
                  state_d  = COMPUTE;
                  cnt_d    = '0;
                  settle_d = SW'(SETTLE);
               end
            end
         end
         COMPUTE: begin
            // samples are frozen here, so the core output is stable by the last settle cycle
            if (settle_q <= SW'(1)) begin
               res_re_d = fft_re;
               res_im_d = fft_im;
               settle_d = '0;
               state_d  = DRAIN;
            end else begin
               settle_d = settle_q - 1'b1;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == IDX_W'(N_PTS - 1)) begin
                  frame_done = 1'b1;
                  idx_d      = '0;
                  state_d    = LOAD;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   assign out_re  = res_re_q[idx_q];
   assign out_im  = res_im_q[idx_q];
   assign out_idx = idx_q;
   assign busy    = (state_q != LOAD) || (cnt_q != '0);

endmodule

// File: tb/tb_fft8_frame_seq.sv
// Directed frames with hand-computed bins, plus reset and stall corner cases.
module tb_fft8_frame_seq;

   localparam int DW     = 4;
   localparam int SETTLE = 3;

   logic          clk, rst;
   logic          in_valid, in_ready, out_valid, out_ready, busy, frame_done;
   logic [DW-1:0] in_data, out_re, out_im;
   logic [2:0]    out_idx;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [3:0] s  [8];
      logic [3:0] re [8];
      logic [3:0] im [8];
      bit         stall;
      bit         jam;
   } vec_t;

   vec_t vecs [5];

   fft8_frame_seq #(.DW(DW), .SETTLE(SETTLE)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_re     (out_re),
      .out_im     (out_im),
      .out_idx    (out_idx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic load_frame(input int vi, output int t_first);
      t_first = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = vecs[vi].s[n];
         #1;
         chk("in_ready_load", int'(in_ready), 1);
         chk("busy_load", int'(busy), (n == 0) ? 0 : 1);
         if (n == 0) begin
            t_first = cyc;
            chk("frame_done_idle", int'(frame_done), 0);
         end
      end
   endtask

   task automatic drain_frame(input int vi, input int t_first);
      int k     = 0;
      int ph    = 0;
      int guard = 0;
      bit seen  = 1'b0;
      while (k < 8 && guard < 200) begin
         @(negedge clk);
         guard++;
         in_valid  = vecs[vi].jam;
         in_data   = 4'hA;
         out_ready = vecs[vi].stall ? (ph % 3 == 0) : 1'b1;
         ph++;
         #1;
         chk("busy_frame", int'(busy), 1);
         chk("in_ready_busy", int'(in_ready), 0);
         if (out_valid) begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", cyc - t_first, 8 + SETTLE);
            end
            chk("out_idx", int'(out_idx), k);
            chk($sformatf("v%0d_re%0d", vi, k), int'(out_re), int'(vecs[vi].re[k]));
            chk($sformatf("v%0d_im%0d", vi, k), int'(out_im), int'(vecs[vi].im[k]));
            chk("frame_done", int'(frame_done), int'(out_ready && k == 7));
            if (out_ready) k++;
         end else begin
            chk("frame_done_nv", int'(frame_done), 0);
         end
      end
      in_valid = 1'b0;
      if (k != 8) chk("drain_timeout", k, 8);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, int'(out_valid), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_out_re"}, int'(out_re), 0);
      chk({tag, "_out_im"}, int'(out_im), 0);
      chk({tag, "_out_idx"}, int'(out_idx), 0);
   endtask

   initial begin
      int tf, prev_tf, g;
      tf = 0;
      prev_tf = 0;

      // x = 2,3,0,1: X_k = 2 + 3W^k + W^3k, root-half terms rounded to nearest
      vecs[0].s  = '{4'd2, 4'd3, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[0].re = '{4'd6, 4'd3, 4'd2, 4'd1, 4'd14, 4'd1, 4'd2, 4'd3};
      vecs[0].im = '{4'd0, 4'd13, 4'd14, 4'd13, 4'd0, 4'd3, 4'd2, 4'd3};
      vecs[0].stall = 1'b0;
      vecs[0].jam   = 1'b0;
      vecs[1] = vecs[0];
      vecs[1].stall = 1'b1;
      // all 15: bin0 = 120 mod 16 = 8, every other bin cancels
      vecs[2].s  = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
      vecs[2].re = '{4'd8, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[2].im = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[2].stall = 1'b0;
      vecs[2].jam   = 1'b1;
      // delayed impulse: X_k = W^k, root-half rounds to +/-1
      vecs[3].s  = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[3].re = '{4'd1, 4'd1, 4'd0, 4'd15, 4'd15, 4'd15, 4'd0, 4'd1};
      vecs[3].im = '{4'd0, 4'd15, 4'd15, 4'd15, 4'd0, 4'd1, 4'd1, 4'd1};
      vecs[3].stall = 1'b1;
      vecs[3].jam   = 1'b1;
      vecs[4].s  = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[4].re = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1};
      vecs[4].im = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      vecs[4].stall = 1'b0;
      vecs[4].jam   = 1'b0;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      #2;
      chk_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_in_ready", int'(in_ready), 1);
      chk_reset_outputs("rel");

      // back-to-back table frames; period measured after unstalled frames
      for (int i = 0; i < 5; i++) begin
         load_frame(i, tf);
         if (i > 0 && !vecs[i-1].stall) chk("period", tf - prev_tf, 8 + SETTLE + 8);
         drain_frame(i, tf);
         prev_tf = tf;
      end

      // reset after five samples, then a fresh impulse frame
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 4'd9;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk_reset_outputs("rst_load");
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      load_frame(4, tf);
      drain_frame(4, tf);

      // reset while bins are stalled in drain
      load_frame(0, tf);
      g = 0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      while (!out_valid && g < 30) begin
         @(negedge clk);
         #1;
         g++;
      end
      chk("wait_drain", int'(out_valid), 1);
      @(negedge clk);
      #1;
      chk("stall_hold_idx", int'(out_idx), 0);
      chk("stall_hold_re", int'(out_re), 6);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_drain");
      @(negedge clk);
      rst = 1'b0;
      load_frame(3, tf);
      drain_frame(3, tf);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fft8_frame_seq.md
FFT8_FRAME_SEQ -- requirements
Module: fft8_frame_seq

Interface
REQ-001 Parameter DW, default 4, sample and result component width in bits.
REQ-002 Parameter SETTLE, default 1, number of cycles spent in COMPUTE, range 1..15.
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port in_valid, input, 1, upstream sample present.
REQ-006 Port in_ready, output, 1, block accepts a sample this cycle.
REQ-007 Port in_data, input, DW, real time-domain sample.
REQ-008 Port out_valid, output, 1, result bin present.
REQ-009 Port out_ready, input, 1, downstream accepts the bin.
REQ-010 Port out_re, output, DW, real part of the current bin.
REQ-011 Port out_im, output, DW, imaginary part of the current bin.
REQ-012 Port out_idx, output, 3, bin index 0..7 of the current bin.
REQ-013 Port busy, output, 1, high whenever the state is not LOAD or the sample count is nonzero.
REQ-014 Port frame_done, output, 1, one-cycle pulse when bin 7 is accepted downstream.

Function
REQ-015 The FSM SHALL have exactly three states: LOAD, COMPUTE and DRAIN.
REQ-016 In LOAD, in_ready=1; each cycle with in_valid=1 the block SHALL store in_data into sample register A[cnt] and increment 3-bit cnt.
REQ-017 Acceptance at cnt=7 SHALL move the FSM to COMPUTE, clear cnt and load the settle counter with SETTLE.
REQ-018 in_ready SHALL be 0 in COMPUTE and DRAIN, and in_valid SHALL be ignored there.
REQ-019 A0..A7 SHALL drive one fft8 instance continuously; the registers SHALL not change outside LOAD acceptances.
REQ-020 In COMPUTE the settle counter SHALL decrement each cycle; on the cycle it reaches 1, all 16 fft8 outputs SHALL be captured into result registers and the FSM SHALL enter DRAIN.
REQ-021 In DRAIN, out_valid=1, and out_re/out_im/out_idx SHALL present captured bin out_idx, starting at 0.
REQ-022 The outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 On out_valid and out_ready, out_idx SHALL increment; acceptance at out_idx=7 SHALL pulse frame_done, reset out_idx to 0 and return the FSM to LOAD.
REQ-024 out_valid SHALL be 0 outside DRAIN.
REQ-025 Result values SHALL be the fft8 outputs as produced, DW bits wide, modulo 2^DW, with no saturation or rescaling.
REQ-026 Back-to-back frames: the first sample of the next frame SHALL be accepted no earlier than the cycle after frame_done.
REQ-027 Minimum frame period SHALL be 8 + SETTLE + 8 cycles with in_valid and out_ready held high.

Reset
REQ-028 Assertion of rst SHALL set, asynchronously: state=LOAD, cnt=0, out_idx=0, settle counter=0, A0..A7=0, result registers=0.
REQ-029 During and immediately after reset the outputs SHALL be: in_ready=1 after release, out_valid=0, frame_done=0, busy=0, out_re=out_im=0.
REQ-030 Reset mid-frame, in any state, SHALL discard all partial samples and undelivered bins with no frame_done pulse.

Structure
REQ-031 A shared package fft8_seq_pkg SHALL hold the state encoding, N_PTS=8 and the index width of 3.
REQ-032 The existing fft8 core SHALL be the sole sub-module, instantiated once; the sequencer SHALL contain no arithmetic besides counters.

Verification
REQ-033 Load 2,3,0,1,0,0,0,0 with in_valid held high and out_ready held high -> bins 0..7 emerge in order after 8+SETTLE cycles, equal to the combinational fft8 outputs for the same vector, with bin0 re=6 im=0; frame_done pulses once.
REQ-034 Drain the same frame with out_ready toggled 1,0,0,1... -> no bin skipped or duplicated, and data stable during stalls.
REQ-035 Load an all-15 frame, 8 x 4'hF -> bin0 re=(8*15) mod 16=8, im=0, confirming wrap-around without saturation.
REQ-036 Assert rst after the 5th sample, then load a full new frame -> the output reflects only the new frame, with no stale bins.
REQ-037 Drive in_valid continuously during COMPUTE/DRAIN -> in_ready=0, those samples are not stored, and the next frame starts after frame_done.
REQ-038 Run two back-to-back frames with SETTLE=3 -> period of exactly 19 cycles, and busy deasserts only between frames.
